// File: rtl/stack_spill_if.sv
// stack_spill_if: groups the decoder/ALU op port and the data-memory req/ack
// port of the operand stack. The slave modport is the stack's view; the
// master modport is the view of whoever drives ops and answers memory.
interface stack_spill_if #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 16
);
  localparam int DW = $clog2(DEPTH + 1);

  // Decoder / ALU side
  logic [2:0]        op;
  logic              op_valid;
  logic [WIDTH-1:0]  data_in;
  logic [WIDTH-1:0]  data0;
  logic [WIDTH-1:0]  data1;
  logic [DW-1:0]     depth;
  logic              busy;
  logic              ovf;
  logic              unf;

  // Data-memory side
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [WIDTH-1:0]  mem_wdata;
  logic [WIDTH-1:0]  mem_rdata;
  logic              mem_ack;

  modport slave (
    input  op, op_valid, data_in, mem_rdata, mem_ack,
    output data0, data1, depth, busy, ovf, unf,
           mem_req, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output op, op_valid, data_in, mem_rdata, mem_ack,
    input  data0, data1, depth, busy, ovf, unf,
           mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/stack_spill.sv
// stack_spill: DEPTH-entry operand stack (entry 0 on top) with depth tracking,
// DUP/SWAP/CLEAR, sticky overflow/underflow, and optional spill/fill of the
// bottom entry to data memory.
// Build option: define STACK_SPILL_EN to enable the spill/fill FSM and the
// memory port. Without it a full push discards the bottom entry and sets ovf,
// and the memory port is held idle.
module stack_spill #(
  parameter int               WIDTH       = 16,
  parameter int               DEPTH       = 16,
  parameter int               SPILL_DEPTH = 256,
  parameter int               ADDR_W      = 16,
  parameter logic [ADDR_W-1:0] SPILL_BASE = 16'h0F00
) (
  input logic          clk,
  input logic          rst,
  stack_spill_if.slave bus
);
  localparam int DW = $clog2(DEPTH + 1);

  localparam logic [2:0] OP_NOP     = 3'd0;
  localparam logic [2:0] OP_LOAD    = 3'd1;
  localparam logic [2:0] OP_PUSH    = 3'd2;
  localparam logic [2:0] OP_POP     = 3'd3;
  localparam logic [2:0] OP_POPLOAD = 3'd4;
  localparam logic [2:0] OP_DUP     = 3'd5;
  localparam logic [2:0] OP_SWAP    = 3'd6;
  localparam logic [2:0] OP_CLEAR   = 3'd7;

  logic [WIDTH-1:0] stk_q [DEPTH];
  logic [WIDTH-1:0] stk_d [DEPTH];
  logic [DW-1:0]    depth_q, depth_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic accept_s;      // op taken this cycle
  logic push_full_s;   // PUSH/DUP issued with the on-chip stack full
  logic pop_s;         // POP/POPLOAD actually removed an entry
  logic clear_s;       // CLEAR taken
  logic busy_s;        // spill/fill in progress
  logic spill_room_s;  // a full push may spill instead of discarding
  logic fill_done_s;   // fill data arrives this cycle

  assign accept_s = bus.op_valid & ~busy_s;

  // Stack datapath next state: op decode, fill write-back, flag updates.
  always_comb begin
    stk_d       = stk_q;
    depth_d     = depth_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    push_full_s = 1'b0;
    pop_s       = 1'b0;
    clear_s     = 1'b0;
    if (accept_s) begin
      case (bus.op)
        OP_NOP: begin
          stk_d = stk_q;
        end
        OP_LOAD: begin
          stk_d[0] = bus.data_in;
          if (depth_q == '0) begin
            depth_d = DW'(1);
          end else begin
            depth_d = depth_q;
          end
        end
        OP_PUSH, OP_DUP: begin
          if ((bus.op == OP_DUP) && (depth_q == '0)) begin
            unf_d = 1'b1;
          end else begin
            // Shift down; entry 0 keeps its value for DUP.
            for (int i = DEPTH - 1; i >= 1; i--) begin
              stk_d[i] = stk_q[i-1];
            end
            if (bus.op == OP_PUSH) begin
              stk_d[0] = bus.data_in;
            end else begin
              stk_d[0] = stk_q[0];
            end
            if (depth_q == DW'(DEPTH)) begin
              // Old bottom entry leaves: spilled if room, otherwise lost.
              push_full_s = 1'b1;
              if (!spill_room_s) begin
                ovf_d = 1'b1;
              end else begin
                ovf_d = ovf_q;
              end
            end else begin
              depth_d = depth_q + DW'(1);
            end
          end
        end
        OP_POP: begin
          if (depth_q == '0) begin
            unf_d = 1'b1;
          end else begin
            for (int i = 0; i < DEPTH - 1; i++) begin
              stk_d[i] = stk_q[i+1];
            end
            stk_d[DEPTH-1] = '0;
            depth_d        = depth_q - DW'(1);
            pop_s          = 1'b1;
          end
        end
        OP_POPLOAD: begin
          // Binary-ALU result replaces the two top operands.
          if (depth_q < DW'(2)) begin
            unf_d = 1'b1;
          end else begin
            stk_d[0] = bus.data_in;
            for (int i = 1; i < DEPTH - 1; i++) begin
              stk_d[i] = stk_q[i+1];
            end
            stk_d[DEPTH-1] = '0;
            depth_d        = depth_q - DW'(1);
            pop_s          = 1'b1;
          end
        end
        OP_SWAP: begin
          if (depth_q < DW'(2)) begin
            unf_d = 1'b1;
          end else begin
            stk_d[0] = stk_q[1];
            stk_d[1] = stk_q[0];
          end
        end
        OP_CLEAR: begin
          for (int i = 0; i < DEPTH; i++) begin
            stk_d[i] = '0;
          end
          depth_d = '0;
          ovf_d   = 1'b0;
          unf_d   = 1'b0;
          clear_s = 1'b1;
        end
        default: begin
          stk_d = stk_q;
        end
      endcase
    end else if (fill_done_s) begin
      // A fill always follows a pop from a full stack, so slot DEPTH-1 is free.
      stk_d[DEPTH-1] = bus.mem_rdata;
      depth_d        = depth_q + DW'(1);
    end else begin
      stk_d = stk_q;
    end
  end

  // Stack storage, depth and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stk_q[i] <= '0;
      end
      depth_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      stk_q   <= stk_d;
      depth_q <= depth_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.data0 = stk_q[0];
  assign bus.data1 = stk_q[1];
  assign bus.depth = depth_q;
  assign bus.ovf   = ovf_q;
  assign bus.unf   = unf_q;
  assign bus.busy  = busy_s;

`ifdef STACK_SPILL_EN
  localparam int SW = $clog2(SPILL_DEPTH + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPILL = 2'd1,
    ST_FILL  = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [SW-1:0]     spill_cnt_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [WIDTH-1:0]  mem_wdata_q;
  logic              mem_req_s;
  logic              mem_we_s;

  assign spill_room_s = (spill_cnt_q < SW'(SPILL_DEPTH));
  assign fill_done_s  = (state_q == ST_FILL) & bus.mem_ack;

  // FSM state register; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: start a spill on a full push with room, a fill on a pop
  // while memory holds entries; return to idle on the ack strobe.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (push_full_s && spill_room_s) begin
          state_d = ST_SPILL;
        end else if (pop_s && (spill_cnt_q != '0)) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SPILL, ST_FILL: begin
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: request and direction decoded from the registered state.
  always_comb begin
    busy_s    = 1'b0;
    mem_req_s = 1'b0;
    mem_we_s  = 1'b0;
    case (state_q)
      ST_SPILL: begin
        busy_s    = 1'b1;
        mem_req_s = 1'b1;
        mem_we_s  = 1'b1;
      end
      ST_FILL: begin
        busy_s    = 1'b1;
        mem_req_s = 1'b1;
        mem_we_s  = 1'b0;
      end
      default: begin
        busy_s    = 1'b0;
        mem_req_s = 1'b0;
        mem_we_s  = 1'b0;
      end
    endcase
  end

  // Spill count plus address/data capture; held stable for the whole request.
  always_ff @(posedge clk) begin
    if (rst) begin
      spill_cnt_q <= '0;
      mem_addr_q  <= SPILL_BASE;
      mem_wdata_q <= '0;
    end else if (clear_s) begin
      spill_cnt_q <= '0;
    end else if ((state_q == ST_IDLE) && (state_d == ST_SPILL)) begin
      mem_addr_q  <= SPILL_BASE + ADDR_W'(spill_cnt_q);
      mem_wdata_q <= stk_q[DEPTH-1];
    end else if ((state_q == ST_IDLE) && (state_d == ST_FILL)) begin
      mem_addr_q  <= SPILL_BASE + ADDR_W'(spill_cnt_q) - ADDR_W'(1);
    end else if ((state_q == ST_SPILL) && bus.mem_ack) begin
      spill_cnt_q <= spill_cnt_q + SW'(1);
    end else if ((state_q == ST_FILL) && bus.mem_ack) begin
      spill_cnt_q <= spill_cnt_q - SW'(1);
    end else begin
      spill_cnt_q <= spill_cnt_q;
    end
  end

  assign bus.mem_req   = mem_req_s;
  assign bus.mem_we    = mem_we_s;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
`else
  logic unused_s;

  assign spill_room_s  = 1'b0;
  assign fill_done_s   = 1'b0;
  assign busy_s        = 1'b0;
  assign bus.mem_req   = 1'b0;
  assign bus.mem_we    = 1'b0;
  assign bus.mem_addr  = SPILL_BASE;
  assign bus.mem_wdata = {WIDTH{1'b0}};
  assign unused_s      = ^{bus.mem_rdata, bus.mem_ack, pop_s, clear_s,
                           (SPILL_DEPTH > 0)};
`endif

endmodule

// File: tb/tb_stack_spill.sv
// tb_stack_spill: directed scoreboard bench for stack_spill (DEPTH=4).
// Stimulus pushes expected stack snapshots and expected memory requests into
// queues; two monitors compare them on the falling clock edge.
module tb_stack_spill;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int SD = 2;
  localparam int AW = 16;

  localparam logic [2:0] NOP = 3'd0, LOAD = 3'd1, PUSH = 3'd2, POP = 3'd3,
                         POPLOAD = 3'd4, DUP = 3'd5, SWAP = 3'd6, CLEAR = 3'd7;

  typedef struct {
    int          cyc;
    string       name;
    logic [15:0] d0;
    logic [15:0] d1;
    logic [2:0]  dep;
    logic        busy;
    logic        ovf;
    logic        unf;
    bit          chk_mem;
  } exp_t;

  typedef struct {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    bit          chk_wdata;
  } mexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   npass = 0;
  int   ntotal = 0;
  bit   chk_mem_v = 1'b0;
  bit   req_prev = 1'b0;

  exp_t  sq[$];
  mexp_t mq[$];

  stack_spill_if #(.WIDTH(W), .DEPTH(D), .ADDR_W(AW)) bus ();

  stack_spill #(.WIDTH(W), .DEPTH(D), .SPILL_DEPTH(SD), .ADDR_W(AW),
                .SPILL_BASE(16'h0F00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Stack-state monitor: compares snapshots scheduled for this cycle.
  always @(negedge clk) begin
    while (sq.size() > 0 && sq[0].cyc <= cyc) begin
      exp_t e;
      e = sq.pop_front();
      chk({e.name, ".data0"}, 32'(bus.data0), 32'(e.d0));
      chk({e.name, ".data1"}, 32'(bus.data1), 32'(e.d1));
      chk({e.name, ".depth"}, 32'(bus.depth), 32'(e.dep));
      chk({e.name, ".busy"},  32'(bus.busy),  32'(e.busy));
      chk({e.name, ".mem_req"}, 32'(bus.mem_req), 32'(e.busy));
      chk({e.name, ".ovf"},   32'(bus.ovf),   32'(e.ovf));
      chk({e.name, ".unf"},   32'(bus.unf),   32'(e.unf));
      if (e.chk_mem) begin
        chk({e.name, ".mem_we"},    32'(bus.mem_we),    32'd0);
        chk({e.name, ".mem_addr"},  32'(bus.mem_addr),  32'h0F00);
        chk({e.name, ".mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
      end
    end
  end

  // Memory monitor: every new request must match the next expected one.
  always @(negedge clk) begin
    if (bus.mem_req === 1'b1 && !req_prev) begin
      if (mq.size() == 0) begin
        ntotal++;
        $display("FAIL mem_req: unexpected request addr=%0h we=%0b expected none",
                 bus.mem_addr, bus.mem_we);
      end else begin
        mexp_t m;
        m = mq.pop_front();
        chk("mem.we", 32'(bus.mem_we), 32'(m.we));
        chk("mem.addr", 32'(bus.mem_addr), 32'(m.addr));
        if (m.chk_wdata) chk("mem.wdata", 32'(bus.mem_wdata), 32'(m.wdata));
      end
    end
    req_prev = (bus.mem_req === 1'b1);
  end

  task automatic expect_st(input string name, input logic [15:0] d0, input logic [15:0] d1,
                           input logic [2:0] dep, input logic busy, input logic ovf,
                           input logic unf);
    exp_t e;
    e.cyc = cyc; e.name = name; e.d0 = d0; e.d1 = d1; e.dep = dep;
    e.busy = busy; e.ovf = ovf; e.unf = unf; e.chk_mem = chk_mem_v;
    sq.push_back(e);
  endtask

  task automatic expect_mem(input logic we, input logic [15:0] addr,
                            input logic [15:0] wdata, input bit cw);
    mexp_t m;
    m.we = we; m.addr = addr; m.wdata = wdata; m.chk_wdata = cw;
    mq.push_back(m);
  endtask

  task automatic issue(input logic [2:0] o, input logic [15:0] d);
    bus.op = o; bus.op_valid = 1'b1; bus.data_in = d;
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op = NOP; bus.data_in = 16'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Wait (bounded) for an outstanding request, then strobe ack for one cycle.
  task automatic ack(input logic [15:0] rdata);
    int n;
    n = 0;
    while (bus.mem_req !== 1'b1 && n < 20) begin idle(1); n++; end
    if (bus.mem_req !== 1'b1) begin
      ntotal++;
      $display("FAIL ack_wait: mem_req still %0b after %0d cycles, required 1", bus.mem_req, n);
    end
    bus.mem_ack = 1'b1; bus.mem_rdata = rdata;
    @(posedge clk); #1;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'd0;
  endtask

  initial begin
    bus.op = NOP; bus.op_valid = 1'b0; bus.data_in = 16'd0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'd0;
`ifdef STACK_SPILL_EN
    chk_mem_v = 1'b0;
`else
    chk_mem_v = 1'b1;
`endif
    idle(2);
    begin
      bit save;
      save = chk_mem_v; chk_mem_v = 1'b1;
      expect_st("reset", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
      chk_mem_v = save;
    end
    rst = 1'b0;

    // Basic push / popload
    issue(PUSH, 16'd1);    expect_st("push1", 16'd1, 16'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    issue(PUSH, 16'd2);    expect_st("push2", 16'd2, 16'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    issue(PUSH, 16'd3);    expect_st("push3", 16'd3, 16'd2, 3'd3, 1'b0, 1'b0, 1'b0);
    issue(POPLOAD, 16'd9); expect_st("popload9", 16'd9, 16'd1, 3'd2, 1'b0, 1'b0, 1'b0);
    issue(CLEAR, 16'd0);   expect_st("clear1", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Underflow cases on an empty / short stack
    issue(POP, 16'd0);     expect_st("pop_empty", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    issue(SWAP, 16'd0);    expect_st("swap_empty", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    issue(CLEAR, 16'd0);   expect_st("clear_unf", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    issue(DUP, 16'd0);     expect_st("dup_empty", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    issue(CLEAR, 16'd0);   expect_st("clear2", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // LOAD / DUP / SWAP / POPLOAD with short stacks
    issue(LOAD, 16'd7);    expect_st("load_empty", 16'd7, 16'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    issue(DUP, 16'd0);     expect_st("dup", 16'd7, 16'd7, 3'd2, 1'b0, 1'b0, 1'b0);
    issue(LOAD, 16'd5);    expect_st("load5", 16'd5, 16'd7, 3'd2, 1'b0, 1'b0, 1'b0);
    issue(SWAP, 16'd0);    expect_st("swap", 16'd7, 16'd5, 3'd2, 1'b0, 1'b0, 1'b0);
    issue(POPLOAD, 16'd4); expect_st("popload4", 16'd4, 16'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    issue(POPLOAD, 16'd8); expect_st("popload_short", 16'd4, 16'd0, 3'd1, 1'b0, 1'b0, 1'b1);
    issue(LOAD, 16'd6);    expect_st("load_d1", 16'd6, 16'd0, 3'd1, 1'b0, 1'b0, 1'b1);
    issue(NOP, 16'd3);     expect_st("nop", 16'd6, 16'd0, 3'd1, 1'b0, 1'b0, 1'b1);
    issue(POP, 16'd0);     expect_st("pop_last", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b1);
    issue(CLEAR, 16'd0);   expect_st("clear3", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Fill the on-chip stack
    for (int i = 1; i <= 4; i++) issue(PUSH, 16'(i));
    expect_st("push4", 16'd4, 16'd3, 3'd4, 1'b0, 1'b0, 1'b0);

`ifdef STACK_SPILL_EN
    expect_mem(1'b1, 16'h0F00, 16'd1, 1'b1);
    issue(PUSH, 16'd5);    expect_st("spill_req", 16'd5, 16'd4, 3'd4, 1'b1, 1'b0, 1'b0);
    issue(PUSH, 16'd99);   expect_st("drop_busy", 16'd5, 16'd4, 3'd4, 1'b1, 1'b0, 1'b0);
    idle(2);
    ack(16'd0);            expect_st("spill_done", 16'd5, 16'd4, 3'd4, 1'b0, 1'b0, 1'b0);
    expect_mem(1'b1, 16'h0F01, 16'd2, 1'b1);
    issue(PUSH, 16'd6);    expect_st("spill2_req", 16'd6, 16'd5, 3'd4, 1'b1, 1'b0, 1'b0);
    ack(16'd0);            expect_st("spill2_done", 16'd6, 16'd5, 3'd4, 1'b0, 1'b0, 1'b0);
    issue(PUSH, 16'd7);    expect_st("spill_full_ovf", 16'd7, 16'd6, 3'd4, 1'b0, 1'b1, 1'b0);
    // Stack 7,6,5,4 ; memory holds 1 at F00, 2 at F01
    expect_mem(1'b0, 16'h0F01, 16'd0, 1'b0);
    issue(POP, 16'd0);     expect_st("fill_req", 16'd6, 16'd5, 3'd3, 1'b1, 1'b1, 1'b0);
    ack(16'd2);            expect_st("fill_done", 16'd6, 16'd5, 3'd4, 1'b0, 1'b1, 1'b0);
    expect_mem(1'b0, 16'h0F00, 16'd0, 1'b0);
    issue(POP, 16'd0);     expect_st("fill2_req", 16'd5, 16'd4, 3'd3, 1'b1, 1'b1, 1'b0);
    ack(16'd1);            expect_st("fill2_done", 16'd5, 16'd4, 3'd4, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("drain1", 16'd4, 16'd2, 3'd3, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("drain2", 16'd2, 16'd1, 3'd2, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("drain3", 16'd1, 16'd0, 3'd1, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("drain4", 16'd0, 16'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    issue(CLEAR, 16'd0);   expect_st("clear_ovf", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);

    // Reset while a spill waits for its ack
    for (int i = 1; i <= 4; i++) issue(PUSH, 16'(i));
    expect_mem(1'b1, 16'h0F00, 16'd1, 1'b1);
    issue(PUSH, 16'd5);    expect_st("spill3_req", 16'd5, 16'd4, 3'd4, 1'b1, 1'b0, 1'b0);
    idle(2);
    rst = 1'b1;
    idle(1);
    chk_mem_v = 1'b1;
    expect_st("rst_abort", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    idle(1);
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'd0;
    expect_st("late_ack", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    chk_mem_v = 1'b0;
    issue(PUSH, 16'd8);    expect_st("after_abort", 16'd8, 16'd0, 3'd1, 1'b0, 1'b0, 1'b0);
    issue(POP, 16'd0);     expect_st("pop_nofill", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
`else
    issue(PUSH, 16'd5);    expect_st("push_full_ovf", 16'd5, 16'd4, 3'd4, 1'b0, 1'b1, 1'b0);
    issue(DUP, 16'd0);     expect_st("dup_full_ovf", 16'd5, 16'd5, 3'd4, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("pop_full1", 16'd5, 16'd4, 3'd3, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("pop_full2", 16'd4, 16'd3, 3'd2, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("pop_full3", 16'd3, 16'd0, 3'd1, 1'b0, 1'b1, 1'b0);
    issue(POP, 16'd0);     expect_st("pop_full4", 16'd0, 16'd0, 3'd0, 1'b0, 1'b1, 1'b0);
    issue(CLEAR, 16'd0);   expect_st("clear_ovf", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
    // Stray ack must be ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 16'hBEEF;
    idle(1);
    bus.mem_ack = 1'b0; bus.mem_rdata = 16'd0;
    expect_st("stray_ack", 16'd0, 16'd0, 3'd0, 1'b0, 1'b0, 1'b0);
`endif

    idle(2);
    chk("scoreboard_drained", 32'(sq.size()), 32'd0);
    chk("mem_queue_drained", 32'(mq.size()), 32'd0);
    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end
endmodule

// File: doc/stack_spill.md
# stack_spill

Parametrised operand stack for the comproc CPU core, successor to the fixed 16×16 register stack. It is an encoded-op stack of DEPTH on-chip entries with depth tracking and DUP/SWAP/CLEAR. It raises sticky overflow/underflow flags. It can spill and fill its bottom entry to data memory over a req/ack port, so logical depth exceeds DEPTH. It sits between the decoder/ALU (op, data_in, data0/data1) and the data-memory arbiter.

## Interface
- WIDTH, 16: entry width in bits.
- DEPTH, 16: on-chip entries; must be ≥ 2.
- SPILL_DEPTH, 256: maximum spilled entries in memory.
- ADDR_W, 16: memory address width.
- SPILL_BASE, 16'h0F00: address of spill slot 0; spill area grows upward.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  synchronous active-high reset.
- op  in  3  0 NOP, 1 LOAD, 2 PUSH, 3 POP, 4 POPLOAD, 5 DUP, 6 SWAP, 7 CLEAR.
- op_valid  in  1  op is accepted when op_valid=1 and busy=0.
- data_in  in  WIDTH  operand for LOAD/PUSH/POPLOAD.
- data0  out  WIDTH  top of stack (entry 0).
- data1  out  WIDTH  entry 1.
- depth  out  $clog2(DEPTH+1)  number of valid on-chip entries.
- busy  out  1  spill/fill in progress; ops are ignored.
- ovf  out  1  sticky overflow.
- unf  out  1  sticky underflow.
- mem_req  out  1  memory request, held until ack.
- mem_we  out  1  1 = spill write, 0 = fill read.
- mem_addr  out  ADDR_W  equals SPILL_BASE + slot.
- mem_wdata  out  WIDTH  spilled entry.
- mem_rdata  in  WIDTH  fill data, valid with mem_ack.
- mem_ack  in  1  one-cycle completion strobe.

## Operation
- Storage is entries 0..DEPTH-1, with entry 0 on top. depth counts valid entries. spill_cnt counts entries in memory. Entries at index ≥ depth read 0.
- LOAD: entry0 ← data_in. If depth=0, depth ← 1.
- PUSH: shift down, entry0 ← data_in, depth+1.
- DUP: shift down, entry0 unchanged (copy), depth+1. With depth=0: set unf, no change.
- POP: shift up, zero-fill the last entry, depth−1. With depth=0: set unf, no change.
- POPLOAD: entry0 ← data_in, entries 1.. shift up, depth−1. This gives the binary-ALU result. With depth<2: set unf, no change.
- SWAP: exchange entry0 and entry1. With depth<2: set unf, no change.
- CLEAR: all entries 0, depth 0, spill_cnt 0, ovf/unf cleared. An outstanding request must not exist, because busy blocks all ops.
- Full push (PUSH/DUP at depth=DEPTH):
  - The old entry DEPTH-1 is captured to mem_wdata, the shift completes, and depth stays DEPTH.
  - If spill_cnt<SPILL_DEPTH, the FSM enters SPILL.
  - Otherwise the entry is discarded and ovf is set.
- Fill: after a POP/POPLOAD when spill_cnt>0, the FSM enters FILL. In that case depth was DEPTH before the pop, which is invariant.
- FSM IDLE→SPILL: mem_req=1, mem_we=1, mem_addr=SPILL_BASE+spill_cnt. On mem_ack: spill_cnt+1, back to IDLE.
- FSM IDLE→FILL: mem_req=1, mem_we=0, mem_addr=SPILL_BASE+spill_cnt−1. On mem_ack: entry DEPTH-1 ← mem_rdata, depth+1, spill_cnt−1, back to IDLE.
- busy = (state≠IDLE).

## Timing
- Reset: all entries 0, depth 0, spill_cnt 0, state IDLE. All outputs are 0: data0, data1, busy, ovf, unf, mem_req, mem_we, mem_addr=SPILL_BASE, mem_wdata.
- Op accepted at edge T: the result is visible on data0/data1/depth/flags after T (1-cycle latency).
- Spill/fill triggered at edge T: mem_req and busy are high from T+1 through the cycle where mem_ack=1. They drop after that edge, and the next op is accepted in the following cycle.
- mem_addr, mem_we and mem_wdata are stable while mem_req=1. mem_ack while mem_req=0 is ignored.
- op_valid while busy: the op is dropped, with no flag change.
- rst during SPILL/FILL aborts: mem_req=0 from the next cycle and all state is reset. Memory contents are abandoned.

## Configuration
- STACK_SPILL_EN defined: spill/fill FSM and memory port active as above.
- Undefined:
  - No FSM; busy, mem_req and mem_we are tied 0, mem_addr=SPILL_BASE, mem_wdata=0.
  - A full push discards entry DEPTH-1 and sets ovf. Pops never fill. spill_cnt is absent.

## Test plan
- Reset, then PUSH 1,2,3 → data0=3, data1=2, depth=3. POPLOAD 9 → data0=9, data1=1, depth=2.
- Empty stack: POP, then SWAP → unf=1, depth=0, data0=0. CLEAR → unf=0.
- DEPTH=4, spill on, PUSH 1..5 → after the 5th: busy=1, mem_req=1, mem_we=1, mem_addr=0x0F00, mem_wdata=1. Ack after 3 cycles → busy=0, depth=4, data0=5.
- Continue with POP → mem_req=1, mem_we=0, addr=0x0F00. Ack with rdata=1 → depth=4, entry3=1. Four more POPs return 4,3,2,1 in data0 order.
- Spill off, DEPTH=4, PUSH 1..5 → ovf=1, depth=4, stack 5,4,3,2, and mem_req never asserts.
- Assert rst during a SPILL wait with no ack → mem_req=0 the next cycle, depth=0. A late mem_ack is ignored.
